// File: rtl/muxn_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_pkg
//  Description : Shared types for the registered N-to-1 scanning multiplexer.
//                mode_t names the two operating modes carried on the 'mode'
//                input (0 = manual channel select, 1 = automatic scan).
//  Revision    : 1.0  initial release
// ============================================================================
package muxn_pkg;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_t;

endpackage : muxn_pkg
`default_nettype wire

// File: rtl/muxn_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_scan_if
//  Description : Bundle of data/control signals between N sampled sources
//                and the scanning multiplexer.
//                Inputs to the mux : din (N*W), sel (SW), mode, dwell, en
//                Outputs of the mux: y (W), ch (SW), valid, wrap
//                master = source/controller side, slave = multiplexer side.
//  Revision    : 1.0  initial release
// ============================================================================
interface muxn_scan_if #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int DWELL_W = 8
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0]     din;
    logic [SW-1:0]      sel;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic               en;
    logic [W-1:0]       y;
    logic [SW-1:0]      ch;
    logic               valid;
    logic               wrap;

    modport master (
        output din, sel, mode, dwell, en,
        input  y, ch, valid, wrap
    );

    modport slave (
        input  din, sel, mode, dwell, en,
        output y, ch, valid, wrap
    );

endinterface : muxn_scan_if
`default_nettype wire

// File: rtl/muxn_scan_dwell_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dwell_timer
//  Description : Dwell counter for the channel sequencer.
//                clk     in  system clock
//                n_reset in  asynchronous active-low reset
//                en      in  count one enabled scan cycle
//                clr     in  treat the current count as zero on this edge
//                dwell   in  number of extra cycles to hold each channel
//                tick    out current (possibly cleared) count >= dwell
//  Revision    : 1.0  initial release
// ============================================================================
module dwell_timer #(
    parameter int DWELL_W = 8
) (
    input  wire               clk,
    input  wire               n_reset,
    input  wire               en,
    input  wire               clr,
    input  wire [DWELL_W-1:0] dwell,
    output logic              tick
);

    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cur;

    // A clear on the same edge as a count means this edge is the first one
    // of a fresh dwell, so the comparison must already see zero.
    assign w_cur = clr ? '0 : r_cnt;
    // >= rather than == so that lowering dwell mid-count ends the dwell on
    // the next enabled edge instead of waiting for the counter to overflow.
    // w_cur < dwell whenever it is incremented, so the +1 cannot overflow.
    assign tick  = (w_cur >= dwell);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= tick ? '0 : w_cur + 1'b1;
        end else if (clr) begin
            r_cnt <= '0;
        end
    end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/muxn_scan.sv
`default_nettype none
// ============================================================================
//  Module      : muxn_scan
//  Description : Registered N-to-1 multiplexer with a channel sequencer.
//                clk     in  system clock, rising edge
//                n_reset in  asynchronous active-low reset
//                bus     slave side of muxn_scan_if:
//                        din/sel/mode/dwell/en in, y/ch/valid/wrap out
//                MANUAL: y <= din[sel] on enabled edges (sel >= N gives y=0,
//                valid=0). SCAN: pointer p steps through 0..N-1, holding
//                each channel for dwell+1 enabled edges; wrap pulses on the
//                edge that leaves channel N-1.
//  Revision    : 1.0  initial release
// ============================================================================
module muxn_scan
    import muxn_pkg::*;
#(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int DWELL_W = 8
) (
    input  wire        clk,
    input  wire        n_reset,
    muxn_scan_if.slave bus
);

    localparam int              SW          = $clog2(N);
    localparam logic [SW:0]     c_n         = (SW+1)'(N);
    localparam logic [SW-1:0]   c_last      = SW'(N-1);
    localparam logic [0:0]      c_st_manual = 1'b0;
    localparam logic [0:0]      c_st_scan   = 1'b1;

    // Channel k of the packed input bus; out-of-range k yields zero, which
    // is exactly what manual mode must output for an invalid select.
    function automatic logic [W-1:0] slice(input logic [N*W-1:0] d,
                                           input logic [SW-1:0]  k);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (k == SW'(i)) r = d[i*W +: W];
        end
        return r;
    endfunction

    logic [0:0]    r_state;
    logic [SW-1:0] r_p;
    logic [W-1:0]  r_y;
    logic [SW-1:0] r_ch;
    logic          r_valid;
    logic          r_wrap;

    mode_t         w_mode;
    logic          w_scan;
    logic          w_entry;
    logic          w_sel_ok;
    logic          w_adv;
    logic          w_clr;
    logic          w_tick;

    // The edge is always processed under the mode presented on it; the
    // registered state only serves to spot the MANUAL->SCAN entry edge.
    assign w_mode   = mode_t'(bus.mode);
    assign w_scan   = (w_mode == MODE_SCAN);
    assign w_entry  = w_scan && (r_state == c_st_manual);
    assign w_sel_ok = ({1'b0, bus.sel} < c_n);
    assign w_adv    = w_scan && bus.en;
    // Entering scan restarts the dwell; a valid manual select also parks
    // the counter at zero alongside the pointer.
    assign w_clr    = w_entry || (!w_scan && bus.en && w_sel_ok);

    dwell_timer #(
        .DWELL_W (DWELL_W)
    ) u_timer (
        .clk     (clk),
        .n_reset (n_reset),
        .en      (w_adv),
        .clr     (w_clr),
        .dwell   (bus.dwell),
        .tick    (w_tick)
    );

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= c_st_manual;
            r_p     <= '0;
            r_y     <= '0;
            r_ch    <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_scan ? c_st_scan : c_st_manual;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
            if (bus.en) begin
                if (w_scan) begin
                    r_y     <= slice(bus.din, r_p);
                    r_ch    <= r_p;
                    r_valid <= 1'b1;
                    if (w_tick) begin
                        r_p    <= (r_p == c_last) ? '0 : r_p + 1'b1;
                        r_wrap <= (r_p == c_last);
                    end
                end else begin
                    r_y     <= slice(bus.din, bus.sel);
                    r_ch    <= bus.sel;
                    r_valid <= w_sel_ok;
                    if (w_sel_ok) r_p <= bus.sel;
                end
            end
        end
    end

    assign bus.y     = r_y;
    assign bus.ch    = r_ch;
    assign bus.valid = r_valid;
    assign bus.wrap  = r_wrap;

endmodule : muxn_scan
`default_nettype wire

// File: tb/tb_muxn_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muxn_scan
//  Description : Self-checking bench for muxn_scan. Drives an N=4 and an
//                N=5 instance side by side and compares both against a
//                behavioural model on every clock, plus fixed expectations
//                for the manual table, scan sequences, enable gating,
//                out-of-range select and asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muxn_scan;

    logic clk;
    logic n_reset;

    muxn_scan_if #(.N(4), .W(8), .DWELL_W(8)) b4 ();
    muxn_scan_if #(.N(5), .W(8), .DWELL_W(8)) b5 ();

    logic [31:0] din4;
    logic [39:0] din5;
    logic [1:0]  sel4;
    logic [2:0]  sel5;
    logic        mode4, mode5, en4, en5;
    logic [7:0]  dw4, dw5;

    assign b4.din = din4;  assign b4.sel = sel4;  assign b4.mode = mode4;
    assign b4.dwell = dw4; assign b4.en = en4;
    assign b5.din = din5;  assign b5.sel = sel5;  assign b5.mode = mode5;
    assign b5.dwell = dw5; assign b5.en = en5;

    muxn_scan #(.N(4), .W(8), .DWELL_W(8)) dut4 (.clk(clk), .n_reset(n_reset), .bus(b4));
    muxn_scan #(.N(5), .W(8), .DWELL_W(8)) dut5 (.clk(clk), .n_reset(n_reset), .bus(b5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic cmp(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // ---------------- behavioural model (index 0 = N4, 1 = N5) -------------
    int m_p[2], m_cnt[2], m_y[2], m_ch[2], m_valid[2], m_wrap[2], m_scan[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_p[d] = 0; m_cnt[d] = 0; m_y[d] = 0; m_ch[d] = 0;
            m_valid[d] = 0; m_wrap[d] = 0; m_scan[d] = 0;
        end
    endtask

    function automatic int byte_of(input logic [39:0] d, input int k);
        logic [39:0] t;
        t = d >> (8 * k);
        return int'(t[7:0]);
    endfunction

    task automatic model_edge(input int d, input int n, input logic [39:0] din,
                              input int sel, input int mode, input int dwell,
                              input int en);
        int count;
        bit entering;
        entering  = (mode == 1) && (m_scan[d] == 0);
        m_scan[d] = mode;
        count     = entering ? 0 : m_cnt[d];
        m_wrap[d] = 0;
        if (en == 0) begin
            m_valid[d] = 0;
            if (entering) m_cnt[d] = 0;
        end else if (mode == 1) begin
            m_y[d] = byte_of(din, m_p[d]);
            m_ch[d] = m_p[d];
            m_valid[d] = 1;
            if (count >= dwell) begin
                m_cnt[d] = 0;
                m_wrap[d] = (m_p[d] == n - 1);
                m_p[d] = (m_p[d] + 1) % n;
            end else begin
                m_cnt[d] = count + 1;
            end
        end else if (sel < n) begin
            m_y[d] = byte_of(din, sel); m_ch[d] = sel; m_valid[d] = 1;
            m_p[d] = sel; m_cnt[d] = 0;
        end else begin
            m_y[d] = 0; m_ch[d] = sel; m_valid[d] = 0;
        end
    endtask

    task automatic check_model();
        cmp("n4.y",     int'(b4.y),     m_y[0]);
        cmp("n4.ch",    int'(b4.ch),    m_ch[0]);
        cmp("n4.valid", int'(b4.valid), m_valid[0]);
        cmp("n4.wrap",  int'(b4.wrap),  m_wrap[0]);
        cmp("n5.y",     int'(b5.y),     m_y[1]);
        cmp("n5.ch",    int'(b5.ch),    m_ch[1]);
        cmp("n5.valid", int'(b5.valid), m_valid[1]);
        cmp("n5.wrap",  int'(b5.wrap),  m_wrap[1]);
    endtask

    // One clock: model follows the same inputs the DUTs see, outputs are
    // sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (!n_reset) begin
            model_reset();
        end else begin
            model_edge(0, 4, {8'h00, din4}, int'(sel4), int'(mode4), int'(dw4), int'(en4));
            model_edge(1, 5, din5, int'(sel5), int'(mode5), int'(dw5), int'(en5));
        end
        #1;
        check_model();
    endtask

    typedef struct {
        logic [1:0] sel;
        logic       en;
        int         exp_y;
        int         exp_ch;
        int         exp_valid;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int wraps;
        int held_y, held_ch;
        int exp_resume[5];

        tbl[0] = '{2'd0, 1'b1, 32'h11, 0, 1};
        tbl[1] = '{2'd1, 1'b1, 32'h22, 1, 1};
        tbl[2] = '{2'd2, 1'b1, 32'h33, 2, 1};
        tbl[3] = '{2'd3, 1'b1, 32'h44, 3, 1};
        tbl[4] = '{2'd1, 1'b0, 32'h44, 3, 0};
        tbl[5] = '{2'd2, 1'b1, 32'h33, 2, 1};

        n_reset = 1'b0;
        din4 = 32'h44332211; din5 = 40'h5544332211;
        sel4 = '0; sel5 = '0; mode4 = 0; mode5 = 0; en4 = 0; en5 = 0;
        dw4 = '0; dw5 = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        cmp("reset.y",     int'(b4.y),     0);
        cmp("reset.ch",    int'(b4.ch),    0);
        cmp("reset.valid", int'(b4.valid), 0);
        cmp("reset.wrap",  int'(b4.wrap),  0);
        cmp("reset.n5.ch", int'(b5.ch),    0);
        n_reset = 1'b1;

        // Manual mode table
        for (int i = 0; i < 6; i++) begin
            sel4 = tbl[i].sel; en4 = tbl[i].en;
            step();
            cmp($sformatf("man[%0d].y", i),     int'(b4.y),     tbl[i].exp_y);
            cmp($sformatf("man[%0d].ch", i),    int'(b4.ch),    tbl[i].exp_ch);
            cmp($sformatf("man[%0d].valid", i), int'(b4.valid), tbl[i].exp_valid);
        end

        // Scan, dwell = 0, starting from channel 0
        sel4 = 2'd0; en4 = 1; step();
        mode4 = 1; dw4 = 8'd0;
        for (int k = 0; k < 5; k++) begin
            step();
            cmp($sformatf("scan0[%0d].ch", k),   int'(b4.ch),   k % 4);
            cmp($sformatf("scan0[%0d].y", k),    int'(b4.y),    byte_of({8'h00, din4}, k % 4));
            cmp($sformatf("scan0[%0d].wrap", k), int'(b4.wrap), (k == 3) ? 1 : 0);
        end

        // Scan, dwell = 2: three edges per channel, one wrap per 12 edges
        mode4 = 0; sel4 = 2'd0; step();
        mode4 = 1; dw4 = 8'd2; wraps = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            cmp($sformatf("scan2[%0d].ch", k), int'(b4.ch), k / 3);
            wraps += int'(b4.wrap);
        end
        cmp("scan2.wraps", wraps, 1);

        // Enable gating mid-dwell: two edges into channel 0, then 5 idle
        step(); step();
        held_y = int'(b4.y); held_ch = int'(b4.ch);
        en4 = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            cmp("gate.valid", int'(b4.valid), 0);
            cmp("gate.ch",    int'(b4.ch),    held_ch);
            cmp("gate.y",     int'(b4.y),     held_y);
        end
        en4 = 1;
        exp_resume = '{0, 1, 1, 1, 2};
        for (int k = 0; k < 5; k++) begin
            step();
            cmp($sformatf("resume[%0d].ch", k), int'(b4.ch), exp_resume[k]);
        end

        // N=5: out-of-range select, then scan wraps 4 -> 0
        sel5 = 3'd6; en5 = 1; step();
        cmp("n5.sel6.valid", int'(b5.valid), 0);
        cmp("n5.sel6.y",     int'(b5.y),     0);
        cmp("n5.sel6.ch",    int'(b5.ch),    6);
        mode5 = 1; dw5 = 8'd0;
        for (int k = 0; k < 12; k++) begin
            step();
            cmp($sformatf("n5scan[%0d].ch", k),   int'(b5.ch),   k % 5);
            cmp($sformatf("n5scan[%0d].wrap", k), int'(b5.wrap), (k % 5 == 4) ? 1 : 0);
        end

        // Asynchronous reset between edges while scanning
        #2;
        n_reset = 1'b0;
        #1;
        model_reset();
        cmp("areset.y",     int'(b4.y),     0);
        cmp("areset.ch",    int'(b4.ch),    0);
        cmp("areset.valid", int'(b4.valid), 0);
        cmp("areset.n5.y",  int'(b5.y),     0);
        step();
        n_reset = 1'b1;
        mode4 = 0; mode5 = 0; en4 = 0; en5 = 0;
        step();
        cmp("post_reset.ch", int'(b4.ch), 0);
        // p restarted at 0: entering scan with dwell 0 shows channel 0 first
        mode4 = 1; en4 = 1; dw4 = 8'd0;
        step();
        cmp("post_reset.scan.ch", int'(b4.ch), 0);

        // Randomised traffic against the model
        for (int k = 0; k < 600; k++) begin
            din4 = $urandom(); din5 = {8'($urandom()), 32'($urandom())};
            sel4 = 2'($urandom_range(0, 3)); sel5 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) mode4 = ~mode4;
            if ($urandom_range(0, 15) == 0) mode5 = ~mode5;
            if ($urandom_range(0, 7) == 0) dw4 = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dw5 = 8'($urandom_range(0, 3));
            en4 = ($urandom_range(0, 3) != 0);
            en5 = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_muxn_scan
`default_nettype wire
